uart_cmd_bridge: RTL

Parametrised UART-to-parallel-bus command bridge, successor to the single-byte UART loopback on the flash board. Sits between the `UART` core's byte handshake and an internal memory/register bus (flash controller, CPU-bus window). Decodes framed ping/read/write packets, runs one bus transaction per packet and streams the response back over UART. Includes bus and inter-byte timeouts.

---
 rtl/uart_cmd_bridge.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_bridge.sv
// Purpose: decode UART ping/read/write packets into one bus transaction each and stream the reply back.
// Latency: ping reply strobes 1 cycle after the command byte; bus_req rises 1 cycle after the last payload byte.
// Backpressure: waits on tx_busy between reply bytes; bytes arriving in BUS/RESP are dropped and flagged in rx_overrun.
module uart_cmd_bridge #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 16,
    parameter int BUS_TIMEOUT = 1024,
    parameter int RX_TIMEOUT  = 480000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_ready,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    output logic              bus_req,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output logic              rx_overrun
);
    localparam int AB    = (ADDR_W + 7) / 8;
    localparam int DB    = DATA_W / 8;
    localparam int MAXB  = (AB > DB) ? AB : DB;
    localparam int CNT_W = $clog2(MAXB + 1);
    localparam int MAXT  = (BUS_TIMEOUT > RX_TIMEOUT) ? BUS_TIMEOUT : RX_TIMEOUT;
    localparam int TMR_W = $clog2(MAXT + 1);

    localparam logic [7:0] CMD_PING  = 8'h50;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_UNK   = 8'h3F;
    localparam logic [7:0] RSP_TMO   = 8'h54;

    // RESP is split into SEND (strobe), GAP (mandatory idle cycle) and WAIT (tx_busy drain).
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_BUS, S_SEND, S_GAP, S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    idx_q;
    logic [CNT_W-1:0]    resp_cnt_q;
    logic [TMR_W-1:0]    timer_q;
    logic [DATA_W-1:0]   resp_buf_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;
    logic                ovr_q;

    logic                accept_cmd;
    logic                cmd_take;
    logic                addr_take;
    logic                data_take;
    logic                idx_clr;
    logic                resp_load;
    logic [DATA_W-1:0]   resp_word;
    logic [CNT_W-1:0]    resp_len;
    logic                tx_fire;
    logic                ovr_set;

    // Control-state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        state_d    = state_q;
        tx_ready   = 1'b0;
        accept_cmd = 1'b0;
        cmd_take   = 1'b0;
        addr_take  = 1'b0;
        data_take  = 1'b0;
        idx_clr    = 1'b0;
        resp_load  = 1'b0;
        resp_word  = '0;
        resp_len   = '0;
        tx_fire    = 1'b0;
        ovr_set    = 1'b0;
        case (state_q)
            S_IDLE: accept_cmd = rx_ready;
            S_ADDR: begin
                if (rx_ready) begin
                    addr_take = 1'b1;
                    if (idx_q == CNT_W'(AB - 1)) state_d = we_q ? S_DATA : S_BUS;
                end else if (timer_q == TMR_W'(RX_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    idx_clr = 1'b1;
                end
            end
            S_DATA: begin
                if (rx_ready) begin
                    data_take = 1'b1;
                    if (idx_q == CNT_W'(DB - 1)) state_d = S_BUS;
                end else if (timer_q == TMR_W'(RX_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    idx_clr = 1'b1;
                end
            end
            S_BUS: begin
                ovr_set = rx_ready;
                // An ack in the expiry cycle takes priority over the timeout.
                if (bus_ack) begin
                    state_d   = S_SEND;
                    resp_load = 1'b1;
                    if (we_q) begin
                        resp_word = DATA_W'(RSP_OK) << (DATA_W - 8);
                        resp_len  = CNT_W'(1);
                    end else begin
                        resp_word = bus_rdata;
                        resp_len  = CNT_W'(DB);
                    end
                end else if (timer_q == TMR_W'(BUS_TIMEOUT - 1)) begin
                    state_d   = S_SEND;
                    resp_load = 1'b1;
                    resp_word = DATA_W'(RSP_TMO) << (DATA_W - 8);
                    resp_len  = CNT_W'(1);
                end
            end
            S_SEND: begin
                ovr_set = rx_ready;
                if (!tx_busy) begin
                    tx_ready = 1'b1;
                    tx_fire  = 1'b1;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                ovr_set = rx_ready;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!tx_busy && resp_cnt_q == '0) begin
                    // Returning to IDLE: a byte arriving now is a new command.
                    state_d    = S_IDLE;
                    accept_cmd = rx_ready;
                end else begin
                    ovr_set = rx_ready;
                    if (!tx_busy) state_d = S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept_cmd) begin
            cmd_take = 1'b1;
            if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
                state_d = S_ADDR;
            end else begin
                state_d   = S_SEND;
                resp_load = 1'b1;
                resp_word = DATA_W'((rx_data == CMD_PING) ? CMD_PING : RSP_UNK) << (DATA_W - 8);
                resp_len  = CNT_W'(1);
            end
        end
    end

    // Packet assembly, response buffer, timers and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            resp_cnt_q <= '0;
            timer_q    <= '0;
            resp_buf_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            if (cmd_take) we_q <= (rx_data == CMD_WRITE);
            if (addr_take) addr_q <= ADDR_W'({addr_q, rx_data});
            if (data_take) wdata_q <= DATA_W'({wdata_q, rx_data});

            if (cmd_take || idx_clr)
                idx_q <= '0;
            else if (addr_take)
                idx_q <= (idx_q == CNT_W'(AB - 1)) ? '0 : idx_q + 1'b1;
            else if (data_take)
                idx_q <= (idx_q == CNT_W'(DB - 1)) ? '0 : idx_q + 1'b1;

            if (resp_load) begin
                resp_buf_q <= resp_word;
                resp_cnt_q <= resp_len;
            end else if (tx_fire) begin
                resp_buf_q <= resp_buf_q << 8;
                resp_cnt_q <= resp_cnt_q - 1'b1;
            end

            if (ovr_set) ovr_q <= 1'b1;

            // Timer counts idle RX cycles in ADDR/DATA and request cycles in BUS.
            if (state_d != state_q)
                timer_q <= '0;
            else if ((state_q == S_ADDR || state_q == S_DATA) && rx_ready)
                timer_q <= '0;
            else if (state_q == S_ADDR || state_q == S_DATA || state_q == S_BUS)
                timer_q <= timer_q + 1'b1;
            else
                timer_q <= '0;
        end
    end

    assign tx_data    = resp_buf_q[DATA_W-1 -: 8];
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign bus_we     = we_q;
    assign bus_req    = (state_q == S_BUS);
    assign busy       = (state_q != S_IDLE);
    assign rx_overrun = ovr_q;
endmodule
